// File: rtl/empaquetador_mux.sv
`default_nettype none
// ============================================================================
// Module      : empaquetador_mux
// Description : Packs N_SYM consecutive SYM_W-bit symbols from the 2:1 mux
//               output into one W-bit word. The first symbol goes into the
//               most significant bits. One finished word is held for the next
//               stage while the following word is being collected.
// Ports       : clok        - clock, rising edge
//               reset_L     - asynchronous active-low reset
//               valid_in    - data_in carries a symbol this cycle
//               data_in     - input symbol (SYM_W bits)
//               ready_out   - symbol accepted this cycle (combinational)
//               data_out_8  - packed word (registered, W bits)
//               valid_out   - data_out_8 holds an unconsumed word (registered)
//               ready_in    - downstream takes data_out_8 when valid_out
//               sym_count   - symbols held in the collect register
// Revision    : 1.0 - initial release
// ============================================================================
module empaquetador_mux #(
  parameter int SYM_W = 2,
  parameter int N_SYM = 4
) (
  input  logic                     clok,
  input  logic                     reset_L,
  input  logic                     valid_in,
  input  logic [SYM_W-1:0]         data_in,
  output logic                     ready_out,
  output logic [SYM_W*N_SYM-1:0]   data_out_8,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(N_SYM)-1:0] sym_count
);

  localparam int W   = SYM_W * N_SYM;
  localparam int CW  = $clog2(N_SYM);
  localparam int SHW = $clog2(W) + 1;

  typedef enum logic [0:0] {
    VACIO = 1'b0,
    LLENO = 1'b1
  } state_t;

  state_t         state;
  logic [W-1:0]   collect;
  logic           last_slot;
  logic           accept;
  logic           complete;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   placed;
  logic [W-1:0]   assembled;

  assign last_slot = (sym_count == CW'(N_SYM - 1));

  // Only the completing symbol can stall: the earlier ones go into the
  // collect register, which is independent of the held output word.
  assign ready_out = reset_L && !(last_slot && valid_out && !ready_in);
  assign accept    = valid_in && ready_out;
  assign complete  = accept && last_slot;

  // Symbol k lands at bits [W-1-k*SYM_W -: SYM_W]; expressed as a left shift
  // of (N_SYM-1-k) symbol widths into an otherwise-zero word.
  assign shamt     = SHW'(((N_SYM - 1) - int'(sym_count)) * SYM_W);
  assign placed    = W'(data_in) << shamt;
  assign assembled = collect | placed;

  always_ff @(posedge clok or negedge reset_L) begin
    if (!reset_L) begin
      state      <= VACIO;
      valid_out  <= 1'b0;
      data_out_8 <= '0;
      collect    <= '0;
      sym_count  <= '0;
    end else begin
      // Collect path: data_in is only sampled under accept, so an unknown
      // value on an idle cycle never reaches a register.
      if (accept) begin
        if (complete) begin
          data_out_8 <= assembled;
          collect    <= '0;
          sym_count  <= '0;
        end else begin
          collect    <= assembled;
          sym_count  <= sym_count + 1'b1;
        end
      end

      // Output FSM. In LLENO a completion can only happen together with
      // ready_in (otherwise ready_out is low), so the new word replaces the
      // consumed one back-to-back.
      case (state)
        VACIO: begin
          if (complete) begin
            state     <= LLENO;
            valid_out <= 1'b1;
          end
        end
        LLENO: begin
          if (ready_in && !complete) begin
            state     <= VACIO;
            valid_out <= 1'b0;
          end
        end
        default: begin
          state     <= VACIO;
          valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_empaquetador_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_empaquetador_mux
// Description : Self-checking bench for empaquetador_mux (SYM_W=2, N_SYM=4).
//               Directed vectors with hand-computed expectations, plus hand
//               sequences for reset, output stall and a mux-driven stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_empaquetador_mux;

  logic       clok;
  logic       reset_L;
  logic       valid_in;
  logic [1:0] data_in;
  logic       ready_out;
  logic [7:0] data_out_8;
  logic       valid_out;
  logic       ready_in;
  logic [1:0] sym_count;

  int n_checks;
  int n_fail;

  empaquetador_mux #(
    .SYM_W(2),
    .N_SYM(4)
  ) dut (
    .clok      (clok),
    .reset_L   (reset_L),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .ready_out (ready_out),
    .data_out_8(data_out_8),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sym_count (sym_count)
  );

  initial clok = 1'b0;
  always #5 clok = ~clok;

  // One vector: inputs for a cycle, expected ready_out during the cycle and
  // expected registered outputs right after the edge.
  typedef struct packed {
    logic       v;
    logic [1:0] d;
    logic       r;
    logic       er;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] ec;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t t);
    valid_in = t.v;
    data_in  = t.d;
    ready_in = t.r;
    #1;
    chk({nm, ".ready_out"}, 32'(ready_out), 32'(t.er));
    @(posedge clok);
    #1;
    chk({nm, ".valid_out"}, 32'(valid_out), 32'(t.ev));
    chk({nm, ".data_out_8"}, 32'(data_out_8), 32'(t.ed));
    chk({nm, ".sym_count"}, 32'(sym_count), 32'(t.ec));
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".valid_out"}, 32'(valid_out), 32'd0);
    chk({nm, ".data_out_8"}, 32'(data_out_8), 32'd0);
    chk({nm, ".sym_count"}, 32'(sym_count), 32'd0);
    chk({nm, ".ready_out"}, 32'(ready_out), 32'd0);
  endtask

  initial begin
    logic       sel;
    logic [1:0] src0;
    logic [1:0] src1;

    n_checks = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    valid_in = 1'b0;
    data_in  = 2'b00;
    ready_in = 1'b1;

    //            v     d      r     er    ev    ed     ec
    // Basic pack + streaming: C9 then 1B, ready_out always high
    tbl.push_back({1'b1, 2'b11, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1});
    tbl.push_back({1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2});
    tbl.push_back({1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 2'd3});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'hC9, 2'd0});
    tbl.push_back({1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 8'hC9, 2'd1});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'hC9, 2'd2});
    tbl.push_back({1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'hC9, 2'd3});
    tbl.push_back({1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 8'h1B, 2'd0});
    // Backpressure: three accepted, the completing one stalls, then swaps in
    tbl.push_back({1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h1B, 2'd1});
    tbl.push_back({1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h1B, 2'd2});
    tbl.push_back({1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h1B, 2'd3});
    tbl.push_back({1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h1B, 2'd3});
    tbl.push_back({1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 8'h1B, 2'd3});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'hB1, 2'd0});
    tbl.push_back({1'b0, 2'bxx, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd0});
    // Gaps with X on data_in while idle: 01 x4 -> 55
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd1});
    tbl.push_back({1'b0, 2'bxx, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd1});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd2});
    tbl.push_back({1'b0, 2'bxx, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd2});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd3});
    tbl.push_back({1'b0, 2'bxx, 1'b1, 1'b1, 1'b0, 8'hB1, 2'd3});
    tbl.push_back({1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 8'h55, 2'd0});
    tbl.push_back({1'b0, 2'bxx, 1'b0, 1'b1, 1'b1, 8'h55, 2'd0});
    tbl.push_back({1'b0, 2'bxx, 1'b1, 1'b1, 1'b0, 8'h55, 2'd0});

    // Reset state, released between edges
    #12;
    chk_reset_vals("reset");
    reset_L = 1'b1;
    @(posedge clok);
    #1;
    chk("post_release.valid_out", 32'(valid_out), 32'd0);
    chk("post_release.sym_count", 32'(sym_count), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Completing symbol with ready_in=0 but output empty is not stalled: 66
    run_vec("nostall0", {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h55, 2'd1});
    run_vec("nostall1", {1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 8'h55, 2'd2});
    run_vec("nostall2", {1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'h55, 2'd3});
    run_vec("nostall3", {1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'h66, 2'd0});
    run_vec("partial0", {1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h66, 2'd1});
    run_vec("partial1", {1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 8'h66, 2'd2});

    // Async reset pulse between edges with a pending word and a partial word
    #2;
    reset_L = 1'b0;
    #1;
    chk_reset_vals("midreset");
    #1;
    reset_L = 1'b1;
    run_vec("after_rst0", {1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1});
    run_vec("after_rst1", {1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 2'd2});
    run_vec("after_rst2", {1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 8'h00, 2'd3});
    run_vec("after_rst3", {1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'hAA, 2'd0});
    run_vec("drain",      {1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 8'hAA, 2'd0});

    // Mux-fed stream: selector toggles between sources 11 and 00 -> CC
    src0 = 2'b00;
    src1 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sel = (i % 2 == 0);
      if (i < 3)
        run_vec($sformatf("mux%0d", i),
                {1'b1, (sel ? src1 : src0), 1'b1, 1'b1, 1'b0, 8'hAA, 2'(i + 1)});
      else
        run_vec($sformatf("mux%0d", i),
                {1'b1, (sel ? src1 : src0), 1'b1, 1'b1, 1'b1, 8'hCC, 2'd0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
